// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential nibble multiplier.
// Holds the FSM state type, the default operand width and the partial-product shift amounts.
package mult_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int DEF_N  = 8;
  localparam int H      = DEF_N / 2;
  localparam int SH_PP0 = 0;
  localparam int SH_PP1 = H;
  localparam int SH_PP2 = H;
  localparam int SH_PP3 = 2 * H;

  // First partial-product state at or after index 'from' whose live bit is set, else DONE.
  function automatic state_t first_live(input logic [3:0] live, input logic [2:0] from);
    state_t s;
    s = DONE;
    if (from <= 3'd3 && live[3]) s = PP3;
    if (from <= 3'd2 && live[2]) s = PP2;
    if (from <= 3'd1 && live[1]) s = PP1;
    if (from == 3'd0 && live[0]) s = PP0;
    return s;
  endfunction

endpackage

// File: rtl/mult_seq_pp_unit.sv
// Combinational unsigned H x H multiplier shared by all four partial products.
module mult_seq_pp_unit #(
  parameter int H = 4
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] p
);

  assign p = (2*H)'(x) * (2*H)'(y);

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential N x N multiplier: one H x H unit time-shared over four nibble partial products.
// Optional MULT_SEQ_ZERO_SKIP_EN skips partial products known to be zero.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// PP0   | accumulate A_lo*B_lo << 0 (skipped when approx)
// PP1   | accumulate A_lo*B_hi << H
// PP2   | accumulate A_hi*B_lo << H
// PP3   | accumulate A_hi*B_hi << 2H
// DONE  | R valid, waiting for out_ready
module mult_8x8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] R,
  output logic           busy
);

  localparam int HN    = N / 2;
  localparam int SHF0  = (SH_PP0 / H) * HN;
  localparam int SHF1  = (SH_PP1 / H) * HN;
  localparam int SHF2  = (SH_PP2 / H) * HN;
  localparam int SHF3  = (SH_PP3 / H) * HN;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, b_q;
  logic             approx_q;
  logic [2*N-1:0]   acc;
  logic             take;
  logic             pp_active;
  logic [HN-1:0]    pp_x, pp_y;
  logic [N-1:0]     pp_p;
  logic [2*N-1:0]   pp_shifted;
  logic [3:0]       live_in, live_q;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign busy      = (state_q != IDLE);
  assign R         = acc;
  assign take      = in_valid && in_ready;
  assign pp_active = (state_q == PP0) || (state_q == PP1) ||
                     (state_q == PP2) || (state_q == PP3);

  // Which partial products still need a cycle, for the incoming pair and the held pair.
  always_comb begin
    live_in = 4'b1111;
    live_q  = 4'b1111;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    live_in[0] = !approx && (A[HN-1:0] != '0) && (B[HN-1:0] != '0);
    live_in[1] = (A[HN-1:0] != '0) && (B[N-1:HN] != '0);
    live_in[2] = (A[N-1:HN] != '0) && (B[HN-1:0] != '0);
    live_in[3] = (A[N-1:HN] != '0) && (B[N-1:HN] != '0);
    live_q[0]  = !approx_q && (a_q[HN-1:0] != '0) && (b_q[HN-1:0] != '0);
    live_q[1]  = (a_q[HN-1:0] != '0) && (b_q[N-1:HN] != '0);
    live_q[2]  = (a_q[N-1:HN] != '0) && (b_q[HN-1:0] != '0);
    live_q[3]  = (a_q[N-1:HN] != '0) && (b_q[N-1:HN] != '0);
`else
    live_in[0] = !approx;
    live_q[0]  = !approx_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = first_live(live_in, 3'd0);
      PP0:     state_d = first_live(live_q, 3'd1);
      PP1:     state_d = first_live(live_q, 3'd2);
      PP2:     state_d = first_live(live_q, 3'd3);
      PP3:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pp_x       = '0;
    pp_y       = '0;
    pp_shifted = '0;
    unique case (state_q)
      PP0: begin
        pp_x = a_q[HN-1:0];
        pp_y = b_q[HN-1:0];
      end
      PP1: begin
        pp_x = a_q[HN-1:0];
        pp_y = b_q[N-1:HN];
      end
      PP2: begin
        pp_x = a_q[N-1:HN];
        pp_y = b_q[HN-1:0];
      end
      PP3: begin
        pp_x = a_q[N-1:HN];
        pp_y = b_q[N-1:HN];
      end
      default: ;
    endcase
    unique case (state_q)
      PP0:     pp_shifted = {{N{1'b0}}, pp_p} << SHF0;
      PP1:     pp_shifted = {{N{1'b0}}, pp_p} << SHF1;
      PP2:     pp_shifted = {{N{1'b0}}, pp_p} << SHF2;
      PP3:     pp_shifted = {{N{1'b0}}, pp_p} << SHF3;
      default: pp_shifted = '0;
    endcase
  end

  mult_seq_pp_unit #(.H(HN)) u_pp (
    .x (pp_x),
    .y (pp_y),
    .p (pp_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc      <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_q      <= A;
        b_q      <= B;
        approx_q <= approx;
        acc      <= '0;
      end else if (pp_active) begin
        acc <= acc + pp_shifted;
      end
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl with a result/latency scoreboard.
// Latency expectations follow MULT_SEQ_ZERO_SKIP_EN when it is defined.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A, B;
  logic        approx;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  mult_8x8_seq_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .approx    (approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_r(input logic [7:0] a, input logic [7:0] b, input logic ap);
    logic [15:0] full, lolo;
    full = 16'(a) * 16'(b);
    lolo = 16'(a[3:0]) * 16'(b[3:0]);
    return ap ? full - lolo : full;
  endfunction

  function automatic int model_lat(input logic [7:0] a, input logic [7:0] b, input logic ap);
    int n;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    n = 0;
    if (!ap && a[3:0] != 0 && b[3:0] != 0) n++;
    if (a[3:0] != 0 && b[7:4] != 0) n++;
    if (a[7:4] != 0 && b[3:0] != 0) n++;
    if (a[7:4] != 0 && b[7:4] != 0) n++;
`else
    n = ap ? 3 : 4;
`endif
    return n + 1;
  endfunction

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ap, input int hold);
    int          cyc;
    logic [15:0] er;
    int          el;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; approx = ap; in_valid = 1'b1; out_ready = (hold == 0);
    exp_q.push_back(model_r(a, b, ap));
    lat_q.push_back(model_lat(a, b, ap));
    @(negedge clk);
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); approx = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    check("out_valid_seen", 32'(out_valid), 32'd1);
    check("latency", 32'(cyc), 32'(el));
    check("result", 32'(R), 32'(er));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = 8'($urandom); B = 8'($urandom);
      @(negedge clk);
      check("hold_R", 32'(R), 32'(er));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hold > 0) @(negedge clk);
    else @(negedge clk);
    check("pulse_end", 32'(out_valid), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = 8'h00; B = 8'h00; approx = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    do_op(8'h0D, 8'h0B, 1'b0, 0);
    do_op(8'h35, 8'h27, 1'b1, 0);
    do_op(8'h35, 8'h27, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b0, 0);
    do_op(8'h12, 8'h34, 1'b0, 3);
    do_op(8'h0F, 8'h0F, 1'b0, 0);
    do_op(8'h00, 8'h5A, 1'b0, 0);
    do_op(8'hF0, 8'h0F, 1'b1, 1);

    // Abort in PP2: every nibble nonzero so the state walk is the same with or without skipping.
    A = 8'h9C; B = 8'h7B; approx = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_R", 32'(R), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_8x8_seq_ctrl.md
MULT_8X8_SEQ_CTRL -- requirements
Module: mult_8x8_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width (even); the nibble width H SHALL be N/2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand pair A/B present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port A, input, N bits: multiplicand (unsigned).
REQ-007 The block SHALL have port B, input, N bits: multiplier (unsigned).
REQ-008 The block SHALL have port approx, input, 1 bit: sampled with A/B; 1 omits the A_lo x B_lo partial product.
REQ-009 The block SHALL have port out_valid, output, 1 bit: R holds a completed product.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes R.
REQ-011 The block SHALL have port R, output, 2N bits: product.
REQ-012 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-013 The block SHALL time-share one H x H partial-product unit across four partial products, accumulating into a 2N-bit register.
REQ-014 The FSM SHALL have states IDLE, PP0, PP1, PP2, PP3 and DONE.
REQ-015 The partial products SHALL be PP0 = A_lo x B_lo shifted 0, PP1 = A_lo x B_hi shifted H, PP2 = A_hi x B_lo shifted H, and PP3 = A_hi x B_hi shifted 2H.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur on in_valid && in_ready.
REQ-018 On a transfer, A, B and approx SHALL be registered and the accumulator cleared.
REQ-019 On a transfer, the next state SHALL be PP0, or PP1 if approx = 1.
REQ-020 Each PPk state SHALL last exactly one cycle, add its shifted product to the accumulator, and advance to PPk+1; PP3 SHALL advance to DONE.
REQ-021 Taking the accept cycle as cycle 0, out_valid SHALL rise in cycle 5 (exact) or cycle 4 (approx).
REQ-022 In DONE, out_valid SHALL be 1 and R SHALL equal the accumulator.
REQ-023 The block SHALL leave DONE for IDLE on out_ready.
REQ-024 A new transfer SHALL be possible in the cycle after the DONE handshake, with no combinational in_ready-to-out_ready path.
REQ-025 While out_valid && !out_ready, R SHALL be held stable and in_valid SHALL be ignored.
REQ-026 Accumulator arithmetic SHALL be 2N-bit unsigned and SHALL NOT overflow, since the exact maximum (2^N-1)^2 fits in 2N bits.
REQ-027 An approx result SHALL equal the exact product minus A_lo x B_lo.
REQ-028 A, B and approx changing after acceptance SHALL have no effect on the operation in flight.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 While rst = 1, the block SHALL take state IDLE, accumulator 0, R 0, out_valid 0, busy 0 and in_ready 0.
REQ-031 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-032 rst asserted in any PP or DONE state SHALL abort and discard the operation, with no out_valid pulse.

Configuration
REQ-033 The block SHALL support the macro MULT_SEQ_ZERO_SKIP_EN.
REQ-034 With MULT_SEQ_ZERO_SKIP_EN defined, any PP state whose product is known zero (either nibble operand = 0) SHALL be skipped, the FSM going directly to the next non-skipped state or DONE.
REQ-035 With MULT_SEQ_ZERO_SKIP_EN defined and every remaining product zero, the block SHALL go from IDLE directly to DONE, with out_valid in cycle 1 and R = 0.
REQ-036 With MULT_SEQ_ZERO_SKIP_EN undefined, the latency SHALL be fixed per REQ-021 and independent of operand values.

Structure
REQ-037 Package mult_seq_pkg SHALL hold the state enum type, the default N, and the localparams H and the per-state shift amounts (0, H, H, 2H).
REQ-038 The block SHALL contain exactly one sub-module, mult_seq_pp_unit: a combinational, exact, unsigned H x H multiplier producing 2H bits.
REQ-039 The sub-module SHALL be fed through nibble muxes selected by state.

Verification
REQ-040 A=0x0D, B=0x0B, approx=0, out_ready=1 -> out_valid in cycle 5, R=0x008F, single-cycle pulse.
REQ-041 A=0x35, B=0x27, approx=1 -> out_valid in cycle 4, R=0x07F0; the same operands with approx=0 give R=0x0813.
REQ-042 A=0xFF, B=0xFF, approx=0 -> R=0xFE01, with no overflow.
REQ-043 A=0x12, B=0x34 with out_ready held 0 for 3 cycles after out_valid -> R=0x03A8 stable throughout, in_ready=0, and a new in_valid ignored until the handshake.
REQ-044 rst pulsed in PP2 -> next cycle IDLE, in_ready=1, and no out_valid for the aborted operation.
REQ-045 With MULT_SEQ_ZERO_SKIP_EN defined, A=0x0F, B=0x0F -> out_valid in cycle 2, R=0x00E1; A=0x00, B=0x5A -> out_valid in cycle 1, R=0; with the macro undefined, both give out_valid in cycle 5.
